// File: rtl/csr_def.sv
// ============================================================================
// csr_def : machine-mode trap cause encodings shared across the core.
// Revision: 1.0
// ============================================================================
`default_nettype none

package csr_def;

  typedef enum logic [3:0] {
    EXC_INST_MISALIGNED   = 4'd0,
    EXC_INST_ACCESS_FAULT = 4'd1,
    EXC_ILLEGAL_INST      = 4'd2,
    EXC_BREAKPOINT        = 4'd3,
    EXC_LOAD_MISALIGNED   = 4'd4,
    EXC_LOAD_ACCESS_FAULT = 4'd5,
    EXC_STORE_MISALIGNED  = 4'd6,
    EXC_STORE_ACCESS_FAULT= 4'd7,
    EXC_ECALL_U           = 4'd8,
    EXC_ECALL_S           = 4'd9,
    EXC_ECALL_M           = 4'd11,
    EXC_INST_PAGE_FAULT   = 4'd12,
    EXC_LOAD_PAGE_FAULT   = 4'd13,
    EXC_STORE_PAGE_FAULT  = 4'd15
  } excp_code_t;

endpackage : csr_def

`default_nettype wire

// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// fetch_queue_pkg : entry format passed from fetch to decode.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         inst;
    logic                excp_valid;
    csr_def::excp_code_t excp_code;
    logic                pred_taken;
  } fetch_entry_t;

endpackage : fetch_queue_pkg

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : circular instruction buffer between IFU and decode/issue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  fetch_entry_t in_entry,
  output logic         out_valid,
  input  logic         out_ready,
  output fetch_entry_t out_entry,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] c_full_cnt = (PTR_W+1)'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, empty, enq, deq;

  // Handshake flags depend only on registered occupancy: no ready-to-ready path.
  assign full      = (count_q == c_full_cnt);
  assign empty     = (count_q == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;
  assign out_entry = mem_q[rptr_q];
  assign count     = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq) wptr_d = wptr_q + PTR_W'(1);
      if (deq) rptr_d = rptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; an enqueue in a flush/reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (enq && !flush && !rst) begin
      mem_q[wptr_q] <= in_entry;
    end
  end

  a_no_enq_when_full: assert property (@(posedge clk) disable iff (rst)
    !(enq && full));

  a_count_bounded: assert property (@(posedge clk) disable iff (rst)
    count_q <= c_full_cnt);

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_entry)));

endmodule : fetch_queue

`default_nettype wire
